// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SWAP_OUT   = 2'd1,
      SWAP_IN    = 2'd2,
      SWAP_IN_OK = 2'd3
   } cache_state_e;

   localparam int REPL_LRU  = 0;
   localparam int REPL_FIFO = 1;
   localparam int WORD_W    = 32;

   // A one-way cache still needs a one-bit way index and age field.
   function automatic int clog2_safe(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cache_repl.sv
// Per-set age array: picks the victim way (invalid first, else age 0)
// and keeps the ages of each set a permutation of 0..WAY_CNT-1.
module cache_repl
   import cache_pkg::*;
#(
   parameter int WAY_CNT      = 4,
   parameter int SET_ADDR_LEN = 3,
   parameter int REPL_POLICY  = REPL_LRU,
   localparam int AW          = clog2_safe(WAY_CNT)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SET_ADDR_LEN-1:0] i_set,
   input  logic [WAY_CNT-1:0]      i_valid,
   output logic [AW-1:0]           o_victim,
   input  logic                    i_hit,
   input  logic                    i_fill,
   input  logic [SET_ADDR_LEN-1:0] i_upd_set,
   input  logic [AW-1:0]           i_upd_way
);

   localparam int SETS = 2 ** SET_ADDR_LEN;

   logic [AW-1:0] r_age [SETS][WAY_CNT];
   logic [AW-1:0] w_inv_way;
   logic [AW-1:0] w_old_way;
   logic [AW-1:0] w_upd_age;
   logic          w_touch;

   // FIFO ordering only moves on fills; LRU also refreshes on hits.
   assign w_touch = i_fill | (i_hit & (REPL_POLICY == REPL_LRU));

   // Victim choice and the current age of the way being touched.
   always_comb begin
      w_inv_way = '0;
      w_old_way = '0;
      w_upd_age = '0;
      for (int w = WAY_CNT - 1; w >= 0; w--) begin
         w_inv_way = !i_valid[w] ? AW'(w) : w_inv_way;
         w_old_way = (r_age[i_set][w] == '0) ? AW'(w) : w_old_way;
         w_upd_age = (AW'(w) == i_upd_way) ? r_age[i_upd_set][w] : w_upd_age;
      end
      o_victim = (&i_valid) ? w_old_way : w_inv_way;
   end

   // Age update: touched way becomes youngest, older-than-it ways shift down.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAY_CNT; w++) begin
               r_age[s][w] <= AW'(w);
            end
         end
      end else if (w_touch) begin
         for (int w = 0; w < WAY_CNT; w++) begin
            if (AW'(w) == i_upd_way) begin
               r_age[i_upd_set][w] <= AW'(WAY_CNT - 1);
            end else if (r_age[i_upd_set][w] > w_upd_age) begin
               r_age[i_upd_set][w] <= r_age[i_upd_set][w] - AW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back, write-allocate cache with a line-wide
// req/gnt memory port. Define CACHE_PERF_CNT_EN to add hit/miss/wb counters.
module cache_assoc_wb
   import cache_pkg::*;
#(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 3,
   parameter int TAG_ADDR_LEN  = 7,
   parameter int WAY_CNT       = 4,
   parameter int REPL_POLICY   = REPL_LRU,
   localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN,
   localparam int LINE_W       = WORD_W * (2 ** LINE_ADDR_LEN)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             addr,
   input  logic                    rd_req,
   input  logic                    wr_req,
   input  logic [31:0]             wr_data,
   output logic [31:0]             rd_data,
   output logic                    miss,
   output logic [MEM_ADDR_LEN-1:0] mem_addr,
   output logic                    mem_rd_req,
   output logic                    mem_wr_req,
   output logic [LINE_W-1:0]       mem_wr_line,
   input  logic [LINE_W-1:0]       mem_rd_line,
   input  logic                    mem_gnt
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]             hit_cnt,
   output logic [31:0]             miss_cnt,
   output logic [31:0]             wb_cnt
`endif
);

   localparam int SETS = 2 ** SET_ADDR_LEN;
   localparam int WW   = clog2_safe(WAY_CNT);
   localparam int TLSB = LINE_ADDR_LEN + SET_ADDR_LEN + 2;

   cache_state_e            r_state;
   logic [LINE_W-1:0]       r_line  [SETS][WAY_CNT];
   logic [TAG_ADDR_LEN-1:0] r_tag   [SETS][WAY_CNT];
   logic [WAY_CNT-1:0]      r_valid [SETS];
   logic [WAY_CNT-1:0]      r_dirty [SETS];
   logic [WW-1:0]           r_vic_way;
   logic [TAG_ADDR_LEN-1:0] r_tag_l;
   logic [SET_ADDR_LEN-1:0] r_set_l;
   logic [LINE_W-1:0]       r_fill_line;
   logic [31:0]             r_rd_data;
   logic [LINE_W-1:0]       r_mem_wr_line;
   logic [MEM_ADDR_LEN-1:0] r_mem_addr;
   logic                    r_mem_rd_req;
   logic                    r_mem_wr_req;

   logic [LINE_ADDR_LEN-1:0] w_word;
   logic [SET_ADDR_LEN-1:0]  w_set;
   logic [TAG_ADDR_LEN-1:0]  w_tag;
   logic                     w_req;
   logic                     w_wr;
   logic                     w_hit;
   logic [WW-1:0]            w_hit_way;
   logic [LINE_W-1:0]        w_hit_line;
   logic [WW-1:0]            w_victim;
   logic [LINE_W-1:0]        w_vic_line;
   logic [TAG_ADDR_LEN-1:0]  w_vic_tag;
   logic                     w_vic_wb;
   logic                     w_idle_req;
   logic [31:0]              w_unused_addr;

   assign w_word        = addr[LINE_ADDR_LEN+1:2];
   assign w_set         = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
   assign w_tag         = addr[TLSB +: TAG_ADDR_LEN];
   assign w_unused_addr = addr;
   assign w_req         = rd_req | wr_req;
   assign w_wr          = wr_req & ~rd_req;
   assign w_idle_req    = w_req & (r_state == IDLE);
   assign miss          = w_req & ~(w_hit & (r_state == IDLE));

   // Tag lookup (lowest matching way wins) and victim line/tag/state mux.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_way  = '0;
      w_hit_line = '0;
      w_vic_line = '0;
      w_vic_tag  = '0;
      w_vic_wb   = 1'b0;
      for (int w = WAY_CNT - 1; w >= 0; w--) begin
         w_hit     = w_hit | (r_valid[w_set][w] & (r_tag[w_set][w] == w_tag));
         w_hit_way = (r_valid[w_set][w] & (r_tag[w_set][w] == w_tag)) ? WW'(w) : w_hit_way;
      end
      for (int w = 0; w < WAY_CNT; w++) begin
         w_hit_line = (WW'(w) == w_hit_way) ? r_line[w_set][w] : w_hit_line;
         w_vic_line = (WW'(w) == w_victim) ? r_line[w_set][w] : w_vic_line;
         w_vic_tag  = (WW'(w) == w_victim) ? r_tag[w_set][w] : w_vic_tag;
         w_vic_wb   = (WW'(w) == w_victim) ? (r_valid[w_set][w] & r_dirty[w_set][w]) : w_vic_wb;
      end
   end

   cache_repl #(
      .WAY_CNT      (WAY_CNT),
      .SET_ADDR_LEN (SET_ADDR_LEN),
      .REPL_POLICY  (REPL_POLICY)
   ) u_repl (
      .clk       (clk),
      .rst       (rst),
      .i_set     (w_set),
      .i_valid   (r_valid[w_set]),
      .o_victim  (w_victim),
      .i_hit     (w_idle_req & w_hit),
      .i_fill    (r_state == SWAP_IN_OK),
      .i_upd_set ((r_state == SWAP_IN_OK) ? r_set_l : w_set),
      .i_upd_way ((r_state == SWAP_IN_OK) ? r_vic_way : w_hit_way)
   );

   // Control FSM with registered memory-port outputs and line state bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_rd_data     <= 32'h0000_0000;
         r_mem_wr_line <= '0;
         r_mem_addr    <= '0;
         r_mem_rd_req  <= 1'b0;
         r_mem_wr_req  <= 1'b0;
         r_vic_way     <= '0;
         r_tag_l       <= '0;
         r_set_l       <= '0;
         r_fill_line   <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req && w_hit) begin
                  if (w_wr) begin
                     r_dirty[w_set][w_hit_way] <= 1'b1;
                  end else begin
                     r_rd_data <= w_hit_line[{w_word, 5'b00000} +: WORD_W];
                  end
               end else if (w_req) begin
                  r_vic_way <= w_victim;
                  r_tag_l   <= w_tag;
                  r_set_l   <= w_set;
                  if (w_vic_wb) begin
                     r_state       <= SWAP_OUT;
                     r_mem_wr_line <= w_vic_line;
                     r_mem_wr_req  <= 1'b1;
                     r_mem_addr    <= {w_vic_tag, w_set};
                  end else begin
                     r_state      <= SWAP_IN;
                     r_mem_rd_req <= 1'b1;
                     r_mem_addr   <= {w_tag, w_set};
                  end
               end
            end
            SWAP_OUT: begin
               if (mem_gnt) begin
                  r_state      <= SWAP_IN;
                  r_mem_wr_req <= 1'b0;
                  r_mem_rd_req <= 1'b1;
                  r_mem_addr   <= {r_tag_l, r_set_l};
               end
            end
            SWAP_IN: begin
               if (mem_gnt) begin
                  r_state      <= SWAP_IN_OK;
                  r_fill_line  <= mem_rd_line;
                  r_mem_rd_req <= 1'b0;
                  r_mem_addr   <= '0;
               end
            end
            SWAP_IN_OK: begin
               r_state                    <= IDLE;
               r_valid[r_set_l][r_vic_way] <= 1'b1;
               r_dirty[r_set_l][r_vic_way] <= 1'b0;
            end
            default: begin
               r_state      <= IDLE;
               r_mem_rd_req <= 1'b0;
               r_mem_wr_req <= 1'b0;
               r_mem_addr   <= '0;
            end
         endcase
      end
   end

   // Line data and tags carry no reset; validity gates every use.
   always_ff @(posedge clk) begin
      if (!rst && w_idle_req && w_hit && w_wr) begin
         r_line[w_set][w_hit_way][{w_word, 5'b00000} +: WORD_W] <= wr_data;
      end else if (!rst && r_state == SWAP_IN_OK) begin
         r_line[r_set_l][r_vic_way] <= r_fill_line;
         r_tag[r_set_l][r_vic_way]  <= r_tag_l;
      end
   end

   assign rd_data     = r_rd_data;
   assign mem_addr    = r_mem_addr;
   assign mem_rd_req  = r_mem_rd_req;
   assign mem_wr_req  = r_mem_wr_req;
   assign mem_wr_line = r_mem_wr_line;

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic [31:0] r_wb_cnt;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= 32'h0000_0000;
         r_miss_cnt <= 32'h0000_0000;
         r_wb_cnt   <= 32'h0000_0000;
      end else begin
         if (w_idle_req && w_hit && r_hit_cnt != 32'hFFFF_FFFF) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_idle_req && !w_hit && r_miss_cnt != 32'hFFFF_FFFF) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
         if (w_idle_req && !w_hit && w_vic_wb && r_wb_cnt != 32'hFFFF_FFFF) begin
            r_wb_cnt <= r_wb_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
   assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed bench: instance 0 uses LRU, instance 1 uses FIFO; a bench-side
// line memory answers fills and absorbs write-backs.
module tb_cache_assoc_wb;

   localparam int LW = 256;
   localparam int MA = 10;

   logic          clk = 1'b0;
   logic          rst         [2];
   logic [31:0]   addr        [2];
   logic          rd_req      [2];
   logic          wr_req      [2];
   logic [31:0]   wr_data     [2];
   logic [31:0]   rd_data     [2];
   logic          miss        [2];
   logic [MA-1:0] mem_addr    [2];
   logic          mem_rd_req  [2];
   logic          mem_wr_req  [2];
   logic [LW-1:0] mem_wr_line [2];
   logic [LW-1:0] mem_rd_line [2];
   logic          mem_gnt     [2];

   logic [LW-1:0] bmem [int];
   int            n_pass = 0;
   int            n_total = 0;
   logic          both_hi = 1'b0;

   always #5 clk = ~clk;

   cache_assoc_wb #(.REPL_POLICY(0)) u_lru (
      .clk(clk), .rst(rst[0]), .addr(addr[0]), .rd_req(rd_req[0]), .wr_req(wr_req[0]),
      .wr_data(wr_data[0]), .rd_data(rd_data[0]), .miss(miss[0]), .mem_addr(mem_addr[0]),
      .mem_rd_req(mem_rd_req[0]), .mem_wr_req(mem_wr_req[0]), .mem_wr_line(mem_wr_line[0]),
      .mem_rd_line(mem_rd_line[0]), .mem_gnt(mem_gnt[0])
   );

   cache_assoc_wb #(.REPL_POLICY(1)) u_fifo (
      .clk(clk), .rst(rst[1]), .addr(addr[1]), .rd_req(rd_req[1]), .wr_req(wr_req[1]),
      .wr_data(wr_data[1]), .rd_data(rd_data[1]), .miss(miss[1]), .mem_addr(mem_addr[1]),
      .mem_rd_req(mem_rd_req[1]), .mem_wr_req(mem_wr_req[1]), .mem_wr_line(mem_wr_line[1]),
      .mem_rd_line(mem_rd_line[1]), .mem_gnt(mem_gnt[1])
   );

   // Untouched memory line: word k of line la is 0x11 + la*0x100 + k.
   function automatic logic [LW-1:0] line_of(input int d, input logic [MA-1:0] la);
      logic [LW-1:0] l;
      if (bmem.exists(d * 4096 + int'(la))) begin
         l = bmem[d * 4096 + int'(la)];
      end else begin
         for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h11 + 32'(la) * 32'h100 + 32'(k);
      end
      return l;
   endfunction

   // One CPU access, serving memory requests until it hits (bounded).
   task automatic access(input int d, input logic [31:0] a, input logic is_wr,
                         input logic [31:0] wd, output logic missed, output logic [31:0] rdat,
                         output logic saw_wb, output logic [MA-1:0] wb_addr,
                         output logic [LW-1:0] wb_line, output logic [MA-1:0] fill_addr,
                         output logic ok);
      int  wait_c;
      logic done;
      missed = 1'b0; rdat = '0; saw_wb = 1'b0; wb_addr = '0; wb_line = '0;
      fill_addr = '0; ok = 1'b0; wait_c = 0; done = 1'b0;
      addr[d] = a; rd_req[d] = ~is_wr; wr_req[d] = is_wr; wr_data[d] = wd;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (!miss[d]) begin
            done = 1'b1;
         end else begin
            missed = 1'b1;
            if (mem_rd_req[d] && mem_wr_req[d]) both_hi = 1'b1;
            if (mem_wr_req[d] || mem_rd_req[d]) begin
               wait_c++;
               if (mem_wr_req[d]) begin
                  saw_wb = 1'b1; wb_addr = mem_addr[d]; wb_line = mem_wr_line[d];
               end else begin
                  fill_addr = mem_addr[d];
               end
               if (wait_c >= 2) begin
                  mem_gnt[d] = 1'b1;
                  wait_c = 0;
                  if (mem_wr_req[d]) bmem[d * 4096 + int'(mem_addr[d])] = mem_wr_line[d];
                  else mem_rd_line[d] = line_of(d, mem_addr[d]);
               end
            end
            @(posedge clk); #1;
            mem_gnt[d] = 1'b0;
         end
      end
      if (done) begin
         @(posedge clk); #1;
         rdat = rd_data[d];
         ok = 1'b1;
      end
      rd_req[d] = 1'b0; wr_req[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; addr[d] = '0; rd_req[d] = 1'b0; wr_req[d] = 1'b0;
         wr_data[d] = '0; mem_rd_line[d] = '0; mem_gnt[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1; rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      n_total += 7;
      if (miss[0] !== 1'b0) $display("FAIL reset_miss: got %b expected 0", miss[0]); else n_pass++;
      if (rd_data[0] !== 32'h0) $display("FAIL reset_rd_data: got %h expected 0", rd_data[0]); else n_pass++;
      if (rd_data[1] !== 32'h0) $display("FAIL reset_rd_data_fifo: got %h expected 0", rd_data[1]); else n_pass++;
      if (mem_rd_req[0] !== 1'b0) $display("FAIL reset_mem_rd_req: got %b expected 0", mem_rd_req[0]); else n_pass++;
      if (mem_wr_req[0] !== 1'b0) $display("FAIL reset_mem_wr_req: got %b expected 0", mem_wr_req[0]); else n_pass++;
      if (mem_addr[0] !== 10'h0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr[0]); else n_pass++;
      if (mem_wr_line[0] !== '0) $display("FAIL reset_mem_wr_line: got %h expected 0", mem_wr_line[0]); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_first_read();
      logic m, wb, ok; logic [31:0] rd; logic [MA-1:0] wa, fa; logic [LW-1:0] wl;
      access(0, 32'h0000_0000, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      n_total += 4;
      if (!ok || m !== 1'b1) $display("FAIL first_read_miss: ok=%b missed=%b expected 1", ok, m); else n_pass++;
      if (fa !== 10'h000) $display("FAIL first_read_fill_addr: got %h expected 000", fa); else n_pass++;
      if (rd !== 32'h0000_0011) $display("FAIL first_read_data: got %h expected 00000011", rd); else n_pass++;
      if (mem_addr[0] !== 10'h0) $display("FAIL idle_mem_addr: got %h expected 0", mem_addr[0]); else n_pass++;
   endtask

   task automatic test_write_alloc();
      logic m, wb, ok; logic [31:0] rd; logic [MA-1:0] wa, fa; logic [LW-1:0] wl;
      access(0, 32'h0000_0104, 1'b1, 32'hDEAD_BEEF, m, rd, wb, wa, wl, fa, ok);
      n_total += 5;
      if (!ok || m !== 1'b1) $display("FAIL write_miss: ok=%b missed=%b expected 1", ok, m); else n_pass++;
      if (wb !== 1'b0) $display("FAIL write_no_wb: got %b expected 0", wb); else n_pass++;
      if (fa !== 10'h008) $display("FAIL write_fill_addr: got %h expected 008", fa); else n_pass++;
      access(0, 32'h0000_0104, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b0) $display("FAIL write_then_read_hit: ok=%b missed=%b expected 0", ok, m); else n_pass++;
      if (rd !== 32'hDEAD_BEEF) $display("FAIL write_then_read_data: got %h expected deadbeef", rd); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic m, wb, ok; logic [31:0] rd; logic [MA-1:0] wa, fa; logic [LW-1:0] wl;
      access(0, 32'h0000_0000, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      n_total += 5;
      if (!ok || m !== 1'b0 || rd !== 32'h11) $display("FAIL b2b_first: missed=%b data=%h expected 0/00000011", m, rd); else n_pass++;
      access(0, 32'h0000_0104, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b0 || rd !== 32'hDEAD_BEEF) $display("FAIL b2b_second: missed=%b data=%h expected 0/deadbeef", m, rd); else n_pass++;
      addr[0] = 32'h0000_0104; rd_req[0] = 1'b1; wr_req[0] = 1'b1; wr_data[0] = 32'h1234_5678;
      @(negedge clk);
      if (miss[0] !== 1'b0) $display("FAIL rdwr_hit: got miss=%b expected 0", miss[0]); else n_pass++;
      @(posedge clk); #1;
      rd_req[0] = 1'b0; wr_req[0] = 1'b0;
      if (rd_data[0] !== 32'hDEAD_BEEF) $display("FAIL rdwr_is_read: got %h expected deadbeef", rd_data[0]); else n_pass++;
      access(0, 32'h0000_0104, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || rd !== 32'hDEAD_BEEF) $display("FAIL rdwr_no_write: got %h expected deadbeef", rd); else n_pass++;
   endtask

   task automatic test_lru_writeback();
      logic m, wb, ok; logic [31:0] rd; logic [MA-1:0] wa, fa; logic [LW-1:0] wl;
      logic [31:0] seq [6] = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000, 32'h400};
      for (int i = 0; i < 5; i++) access(0, seq[i], 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      access(0, seq[5], 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      n_total += 9;
      if (!ok || wb !== 1'b1) $display("FAIL wb_seen: ok=%b wb=%b expected 1", ok, wb); else n_pass++;
      if (wa !== 10'h008) $display("FAIL wb_addr: got %h expected 008", wa); else n_pass++;
      if (wl[63:32] !== 32'hDEAD_BEEF) $display("FAIL wb_word1: got %h expected deadbeef", wl[63:32]); else n_pass++;
      if (fa !== 10'h020) $display("FAIL wb_fill_addr: got %h expected 020", fa); else n_pass++;
      access(0, 32'h000, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b0) $display("FAIL lru_keep_tag0: missed=%b expected 0", m); else n_pass++;
      access(0, 32'h100, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b1) $display("FAIL lru_evict_tag1: missed=%b expected 1", m); else n_pass++;
      if (wb !== 1'b0) $display("FAIL lru_clean_victim: wb=%b expected 0", wb); else n_pass++;
      if (rd !== 32'h0000_0811) $display("FAIL lru_refill_data: got %h expected 00000811", rd); else n_pass++;
      access(0, 32'h104, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || rd !== 32'hDEAD_BEEF) $display("FAIL wb_roundtrip: got %h expected deadbeef", rd); else n_pass++;
   endtask

   task automatic test_fifo();
      logic m, wb, ok; logic [31:0] rd; logic [MA-1:0] wa, fa; logic [LW-1:0] wl;
      logic [31:0] seq [6] = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000, 32'h400};
      for (int i = 0; i < 6; i++) access(1, seq[i], 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      n_total += 4;
      if (!ok || m !== 1'b1 || wb !== 1'b0) $display("FAIL fifo_fill_400: missed=%b wb=%b expected 1/0", m, wb); else n_pass++;
      access(1, 32'h100, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b0 || rd !== 32'h0000_0811) $display("FAIL fifo_keep_tag1: missed=%b data=%h expected 0/00000811", m, rd); else n_pass++;
      access(1, 32'h000, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b1) $display("FAIL fifo_evict_tag0: missed=%b expected 1", m); else n_pass++;
      if (rd !== 32'h0000_0011) $display("FAIL fifo_refill_data: got %h expected 00000011", rd); else n_pass++;
   endtask

   task automatic test_reset_mid_swap();
      logic m, wb, ok, seen; logic [31:0] rd; logic [MA-1:0] wa, fa; logic [LW-1:0] wl;
      seen = 1'b0;
      addr[0] = 32'h0000_0500; rd_req[0] = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = mem_rd_req[0];
      end
      n_total += 9;
      if (seen !== 1'b1) $display("FAIL mid_swap_in_req: got %b expected 1", seen); else n_pass++;
      @(posedge clk); #1;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0; rd_req[0] = 1'b0;
      @(negedge clk);
      if (mem_rd_req[0] !== 1'b0) $display("FAIL rst_mid_rd_req: got %b expected 0", mem_rd_req[0]); else n_pass++;
      if (mem_addr[0] !== 10'h0) $display("FAIL rst_mid_mem_addr: got %h expected 0", mem_addr[0]); else n_pass++;
      mem_gnt[0] = 1'b1;
      @(posedge clk); #1;
      mem_gnt[0] = 1'b0;
      @(negedge clk);
      if (mem_rd_req[0] !== 1'b0 || mem_wr_req[0] !== 1'b0)
         $display("FAIL late_gnt_ignored: rd=%b wr=%b expected 0/0", mem_rd_req[0], mem_wr_req[0]);
      else n_pass++;
      @(posedge clk); #1;
      access(0, 32'h0000_0500, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b1) $display("FAIL rst_prior_addr_miss: missed=%b expected 1", m); else n_pass++;
      if (fa !== 10'h028) $display("FAIL rst_refill_addr: got %h expected 028", fa); else n_pass++;
      if (rd !== 32'h0000_2811) $display("FAIL rst_refill_data: got %h expected 00002811", rd); else n_pass++;
      access(0, 32'h0000_0000, 1'b0, 32'h0, m, rd, wb, wa, wl, fa, ok);
      if (!ok || m !== 1'b1) $display("FAIL rst_cleared_valid: missed=%b expected 1", m); else n_pass++;
      if (both_hi !== 1'b0) $display("FAIL rd_wr_exclusive: got %b expected 0", both_hi); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_read();
      test_write_alloc();
      test_back_to_back();
      test_lru_writeback();
      test_fifo();
      test_reset_mid_swap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
